// File: rtl/mem_wb_skid_stage.sv
// mem_wb_skid_stage: MEM->WB register with valid/ready handshake and 2-entry skid buffer.
// Optional perf counters (stall_cnt, bubble_cnt) are built only when MEM_WB_PERF_EN is defined.
module mem_wb_skid_stage #(
  parameter int DATA_W  = 32,
  parameter int RADDR_W = 5,
  parameter int CTRL_W  = 3,
  parameter int TAG_W   = 6,
  parameter int CNT_W   = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               flush,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [DATA_W-1:0]  in_mem_rdata,
  input  logic [DATA_W-1:0]  in_alu_res,
  input  logic [RADDR_W-1:0] in_rd,
  input  logic [CTRL_W-1:0]  in_ctrl,
  input  logic [TAG_W-1:0]   in_tag,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [DATA_W-1:0]  out_mem_rdata,
  output logic [DATA_W-1:0]  out_alu_res,
  output logic [RADDR_W-1:0] out_rd,
  output logic [CTRL_W-1:0]  out_ctrl,
  output logic [TAG_W-1:0]   out_tag,
  output logic [CNT_W-1:0]   stall_cnt,
  output logic [CNT_W-1:0]   bubble_cnt
);
  localparam int PW = 2*DATA_W + RADDR_W + CTRL_W + TAG_W;
  typedef enum logic [1:0] {EMPTY, ONE, FULL} state_t;
  state_t        state_q, state_d;
  logic          in_ready_q, in_ready_d;
  logic [PW-1:0] main_q, main_d, skid_q, skid_d, in_pl;
  logic          acc, pop;
  assign in_pl = {in_mem_rdata, in_alu_res, in_rd, in_ctrl, in_tag};
  assign {out_mem_rdata, out_alu_res, out_rd, out_ctrl, out_tag} = main_q;
  assign in_ready  = in_ready_q;
  assign out_valid = (state_q != EMPTY);
  assign acc = in_valid & in_ready_q;
  assign pop = out_valid & out_ready;
  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    case (state_q)
      EMPTY: if (acc) begin
        state_d = ONE;
        main_d  = in_pl;
      end
      ONE: if (acc) begin
        state_d = pop ? ONE : FULL;
        main_d  = pop ? in_pl : main_q;
        skid_d  = pop ? skid_q : in_pl;
      end else if (pop) begin
        state_d = EMPTY;
      end
      FULL: if (pop) begin
        state_d = ONE;
        main_d  = skid_q;
      end
      default: state_d = EMPTY;
    endcase
    // flush only clears occupancy; payload registers may hold stale data
    if (flush) state_d = EMPTY;
    in_ready_d = (state_d != FULL);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= EMPTY;
      in_ready_q <= 1'b1;
      main_q     <= '0;
      skid_q     <= '0;
    end else begin
      state_q    <= state_d;
      in_ready_q <= in_ready_d;
      main_q     <= main_d;
      skid_q     <= skid_d;
    end
  end
`ifdef MEM_WB_PERF_EN
  logic [CNT_W-1:0] stall_q, stall_d, bubble_q, bubble_d;
  always_comb begin
    stall_d  = (out_valid & ~out_ready & ~&stall_q) ? stall_q + CNT_W'(1) : stall_q;
    bubble_d = (~out_valid & ~&bubble_q) ? bubble_q + CNT_W'(1) : bubble_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_q  <= '0;
      bubble_q <= '0;
    end else begin
      stall_q  <= stall_d;
      bubble_q <= bubble_d;
    end
  end
  assign stall_cnt  = stall_q;
  assign bubble_cnt = bubble_q;
`else
  assign stall_cnt  = '0;
  assign bubble_cnt = '0;
`endif
endmodule
